// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: bundles the requester-side and memory-side signals of the
// N-channel memory arbiter.
//   master : requester/memory environment (drives requests, memory response)
//   slave  : the arbiter (drives grant, busy, memory strobes and payload)
// Channel i of a packed per-channel field sits at [W*i+W-1:W*i].
interface mem_arbiter_rr_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
);
  logic [NCH-1:0]    req_r;
  logic [NCH-1:0]    req_w;
  logic [2*NCH-1:0]  req_sz;
  logic [AW*NCH-1:0] req_addr;
  logic [DW*NCH-1:0] req_wdata;
  logic [DW-1:0]     req_rdata;
  logic [NCH-1:0]    req_busy;
  logic [NCH-1:0]    gnt;
  logic              mem_r;
  logic              mem_w;
  logic              fetch;
  logic [1:0]        mem_sz;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_busy;

  modport master (
    output req_r, req_w, req_sz, req_addr, req_wdata, mem_rdata, mem_busy,
    input  req_rdata, req_busy, gnt, mem_r, mem_w, fetch, mem_sz, mem_addr, mem_wdata
  );

  modport slave (
    input  req_r, req_w, req_sz, req_addr, req_wdata, mem_rdata, mem_busy,
    output req_rdata, req_busy, gnt, mem_r, mem_w, fetch, mem_sz, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: multiplexes NCH requesters onto a single memory port with
// fixed-priority (RR=0) or round-robin (RR=1) arbitration, and tracks the
// owner of the in-flight transaction so that busy/response reach only it.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_rr_if.slave: per-channel requests in, combinational
//          grant and memory-port payload out, per-channel busy, read data
module mem_arbiter_rr #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter bit          RR       = 1'b1,
  parameter int unsigned FETCH_CH = 0
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_rr_if.slave bus
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] req_c;
  logic [NCH-1:0] gnt_c;
  logic           gnt_vld_c;
  logic [IW-1:0]  gnt_id_c;
  logic           mem_r_c;
  logic           mem_w_c;
  logic [1:0]     sz_c;
  logic [AW-1:0]  addr_c;
  logic [DW-1:0]  wdata_c;

  logic [IW-1:0]  ptr_q, ptr_d;
  logic           owner_vld_q, owner_vld_d;
  logic [IW-1:0]  owner_id_q, owner_id_d;

  // Grant search: first requester at or after the start index, with wrap.
  always_comb begin
    int unsigned idx;
    int unsigned start;
    idx       = 0;
    start     = RR ? 32'(ptr_q) : 0;
    req_c     = bus.req_r | bus.req_w;
    gnt_vld_c = 1'b0;
    gnt_id_c  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = start + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_vld_c && req_c[IW'(idx)]) begin
        gnt_vld_c = 1'b1;
        gnt_id_c  = IW'(idx);
      end
    end
    gnt_c = gnt_vld_c ? (NCH'(1) << gnt_id_c) : '0;
  end

  // Memory-port mux; gnt_id_c is 0 when idle so payload comes from channel 0.
  always_comb begin
    mem_r_c = 1'b0;
    mem_w_c = 1'b0;
    sz_c    = '0;
    addr_c  = '0;
    wdata_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_id_c == IW'(i)) begin
        mem_r_c = gnt_vld_c & bus.req_r[i];
        mem_w_c = gnt_vld_c & bus.req_w[i];
        sz_c    = bus.req_sz[2*i +: 2];
        addr_c  = bus.req_addr[AW*i +: AW];
        wdata_c = bus.req_wdata[DW*i +: DW];
      end
    end
  end

  // Owner and pointer only advance on edges where memory is not stalling.
  always_comb begin
    ptr_d       = ptr_q;
    owner_vld_d = owner_vld_q;
    owner_id_d  = owner_id_q;
    if (!bus.mem_busy) begin
      owner_vld_d = gnt_vld_c;
      owner_id_d  = gnt_id_c;
      if (RR && gnt_vld_c) begin
        ptr_d = (gnt_id_c == IW'(NCH - 1)) ? '0 : gnt_id_c + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      owner_vld_q <= 1'b0;
      owner_id_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_vld_q <= owner_vld_d;
      owner_id_q  <= owner_id_d;
    end
  end

  // Outputs: busy is released only for the owner, and only when memory is not stalling.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      bus.req_busy[i] = !(owner_vld_q && (owner_id_q == IW'(i))) || bus.mem_busy;
    end
    bus.req_rdata = bus.mem_rdata;
    bus.gnt       = gnt_c;
    bus.mem_r     = mem_r_c;
    bus.mem_w     = mem_w_c;
    bus.fetch     = gnt_vld_c && (gnt_id_c == IW'(FETCH_CH));
    bus.mem_sz    = sz_c;
    bus.mem_addr  = addr_c;
    bus.mem_wdata = wdata_c;
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin instance and a fixed-priority
// instance (NCH=4, FETCH_CH=0) share the same stimulus. Expected owners are
// queued when their grant is checked and popped when their response cycle
// comes up.
module tb_mem_arbiter_rr;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req_r;
  logic [NCH-1:0]    req_w;
  logic [2*NCH-1:0]  req_sz;
  logic [AW*NCH-1:0] req_addr;
  logic [DW*NCH-1:0] req_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_busy;

  mem_arbiter_rr_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus_rr ();
  mem_arbiter_rr_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus_fp ();

  assign bus_rr.req_r = req_r;         assign bus_fp.req_r = req_r;
  assign bus_rr.req_w = req_w;         assign bus_fp.req_w = req_w;
  assign bus_rr.req_sz = req_sz;       assign bus_fp.req_sz = req_sz;
  assign bus_rr.req_addr = req_addr;   assign bus_fp.req_addr = req_addr;
  assign bus_rr.req_wdata = req_wdata; assign bus_fp.req_wdata = req_wdata;
  assign bus_rr.mem_rdata = mem_rdata; assign bus_fp.mem_rdata = mem_rdata;
  assign bus_rr.mem_busy = mem_busy;   assign bus_fp.mem_busy = mem_busy;

  mem_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .RR(1'b1), .FETCH_CH(0)) u_rr (
    .clk(clk), .rst(rst), .bus(bus_rr.slave)
  );
  mem_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .RR(1'b0), .FETCH_CH(0)) u_fp (
    .clk(clk), .rst(rst), .bus(bus_fp.slave)
  );

  int total = 0;
  int bad   = 0;
  int unsigned exp_q[$];

  function automatic logic [NCH-1:0] onehot(input int unsigned ch);
    onehot = NCH'(1) << ch;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_r     = '0;
    req_w     = '0;
    req_sz    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_rdata = '0;
    mem_busy  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    #1;
    total++; if (bus_rr.req_busy !== 4'hF) begin bad++; $display("FAIL reset_busy: got %b want 1111", bus_rr.req_busy); end
    total++; if (bus_rr.gnt !== 4'h0) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus_rr.gnt); end
    total++; if (bus_rr.mem_r !== 1'b0) begin bad++; $display("FAIL reset_mem_r: got %b want 0", bus_rr.mem_r); end
    total++; if (bus_rr.mem_w !== 1'b0) begin bad++; $display("FAIL reset_mem_w: got %b want 0", bus_rr.mem_w); end
    total++; if (bus_rr.fetch !== 1'b0) begin bad++; $display("FAIL reset_fetch: got %b want 0", bus_rr.fetch); end
    total++; if (bus_fp.req_busy !== 4'hF) begin bad++; $display("FAIL reset_busy_fp: got %b want 1111", bus_fp.req_busy); end
  endtask

  task automatic test_rr_rotation();
    int unsigned ch;
    do_reset();
    req_r     = '1;
    mem_rdata = 32'hA000_0100;
    #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (bus_rr.gnt !== onehot(k % 4)) begin bad++; $display("FAIL rr_gnt k=%0d: got %b want %b", k, bus_rr.gnt, onehot(k % 4)); end
      if (exp_q.size() > 0) begin
        ch = exp_q.pop_front();
        total++; if (bus_rr.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL rr_busy k=%0d: got %b want %b", k, bus_rr.req_busy, ~onehot(ch)); end
        total++; if (bus_rr.req_rdata !== 32'hA000_0100 + 32'(k)) begin bad++; $display("FAIL rr_rdata k=%0d: got %h want %h", k, bus_rr.req_rdata, 32'hA000_0100 + 32'(k)); end
      end else begin
        total++; if (bus_rr.req_busy !== 4'hF) begin bad++; $display("FAIL rr_busy_first: got %b want 1111", bus_rr.req_busy); end
      end
      exp_q.push_back(k % 4);
      tick();
      mem_rdata = 32'hA000_0100 + 32'(k + 1);
      #1;
    end
    req_r = '0;
    #1;
    ch = exp_q.pop_front();
    total++; if (bus_rr.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL rr_busy_last: got %b want %b", bus_rr.req_busy, ~onehot(ch)); end
    total++; if (bus_rr.gnt !== 4'h0) begin bad++; $display("FAIL rr_gnt_idle: got %b want 0000", bus_rr.gnt); end
  endtask

  task automatic test_fixed_priority();
    int unsigned ch;
    do_reset();
    req_r = 4'b1010;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (bus_fp.gnt !== 4'b0010) begin bad++; $display("FAIL fp_gnt c=%0d: got %b want 0010", c, bus_fp.gnt); end
      if (exp_q.size() > 0) begin
        ch = exp_q.pop_front();
        total++; if (bus_fp.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL fp_busy c=%0d: got %b want %b", c, bus_fp.req_busy, ~onehot(ch)); end
      end
      exp_q.push_back(1);
      tick();
      #1;
    end
    req_r = 4'b1000;
    #1;
    total++; if (bus_fp.gnt !== 4'b1000) begin bad++; $display("FAIL fp_gnt_ch3: got %b want 1000", bus_fp.gnt); end
    ch = exp_q.pop_front();
    total++; if (bus_fp.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL fp_busy_ch1: got %b want %b", bus_fp.req_busy, ~onehot(ch)); end
    exp_q.push_back(3);
    tick();
    req_r = '0;
    #1;
    ch = exp_q.pop_front();
    total++; if (bus_fp.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL fp_busy_ch3: got %b want %b", bus_fp.req_busy, ~onehot(ch)); end
  endtask

  task automatic test_stall();
    int unsigned ch;
    do_reset();
    req_r[2]              = 1'b1;
    req_addr[2*AW +: AW]  = 32'h0000_0100;
    mem_busy              = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (bus_rr.gnt !== 4'b0100) begin bad++; $display("FAIL stall_gnt c=%0d: got %b want 0100", c, bus_rr.gnt); end
      total++; if (bus_rr.mem_addr !== 32'h100 || bus_rr.mem_r !== 1'b1) begin bad++; $display("FAIL stall_port c=%0d: got addr %h r %b want addr 100 r 1", c, bus_rr.mem_addr, bus_rr.mem_r); end
      total++; if (bus_rr.req_busy !== 4'hF) begin bad++; $display("FAIL stall_busy c=%0d: got %b want 1111", c, bus_rr.req_busy); end
      tick();
      #1;
    end
    mem_busy = 1'b0;
    #1;
    total++; if (bus_rr.gnt !== 4'b0100) begin bad++; $display("FAIL stall_gnt_rel: got %b want 0100", bus_rr.gnt); end
    total++; if (bus_rr.req_busy !== 4'hF) begin bad++; $display("FAIL stall_busy_rel: got %b want 1111", bus_rr.req_busy); end
    exp_q.push_back(2);
    tick();
    req_r     = 4'b1001;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    ch = exp_q.pop_front();
    total++; if (bus_rr.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL stall_busy_resp: got %b want %b", bus_rr.req_busy, ~onehot(ch)); end
    total++; if (bus_rr.req_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stall_rdata: got %h want deadbeef", bus_rr.req_rdata); end
    // Pointer advanced past channel 2 only once, so channel 3 beats channel 0.
    total++; if (bus_rr.gnt !== 4'b1000) begin bad++; $display("FAIL stall_ptr_gnt: got %b want 1000", bus_rr.gnt); end
    exp_q.push_back(3);
    tick();
    req_r = '0;
    #1;
    ch = exp_q.pop_front();
    total++; if (bus_rr.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL stall_busy_ch3: got %b want %b", bus_rr.req_busy, ~onehot(ch)); end
  endtask

  task automatic test_back_to_back();
    int unsigned ch;
    do_reset();
    req_w[0]           = 1'b1;
    req_wdata[0 +: DW] = 32'h1234_5678;
    req_sz[1:0]        = 2'd2;
    req_r[1]           = 1'b1;
    #1;
    total++; if (bus_rr.gnt !== 4'b0001) begin bad++; $display("FAIL b2b_gnt0: got %b want 0001", bus_rr.gnt); end
    total++; if (bus_rr.mem_w !== 1'b1 || bus_rr.mem_r !== 1'b0) begin bad++; $display("FAIL b2b_strobe0: got w%b r%b want w1 r0", bus_rr.mem_w, bus_rr.mem_r); end
    total++; if (bus_rr.fetch !== 1'b1) begin bad++; $display("FAIL b2b_fetch0: got %b want 1", bus_rr.fetch); end
    total++; if (bus_rr.mem_wdata !== 32'h1234_5678 || bus_rr.mem_sz !== 2'd2) begin bad++; $display("FAIL b2b_payload: got %h sz %0d want 12345678 sz 2", bus_rr.mem_wdata, bus_rr.mem_sz); end
    exp_q.push_back(0);
    tick();
    req_w[0] = 1'b0;
    #1;
    total++; if (bus_rr.gnt !== 4'b0010) begin bad++; $display("FAIL b2b_gnt1: got %b want 0010", bus_rr.gnt); end
    total++; if (bus_rr.mem_r !== 1'b1 || bus_rr.mem_w !== 1'b0) begin bad++; $display("FAIL b2b_strobe1: got r%b w%b want r1 w0", bus_rr.mem_r, bus_rr.mem_w); end
    total++; if (bus_rr.fetch !== 1'b0) begin bad++; $display("FAIL b2b_fetch1: got %b want 0", bus_rr.fetch); end
    ch = exp_q.pop_front();
    total++; if (bus_rr.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL b2b_busy0: got %b want %b", bus_rr.req_busy, ~onehot(ch)); end
    exp_q.push_back(1);
    tick();
    req_r[1]  = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    #1;
    ch = exp_q.pop_front();
    total++; if (bus_rr.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL b2b_busy1: got %b want %b", bus_rr.req_busy, ~onehot(ch)); end
    total++; if (bus_rr.req_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL b2b_rdata: got %h want 0badf00d", bus_rr.req_rdata); end
    total++; if (bus_rr.gnt !== 4'h0) begin bad++; $display("FAIL b2b_gnt_idle: got %b want 0000", bus_rr.gnt); end
  endtask

  task automatic test_async_reset();
    int unsigned ch;
    do_reset();
    req_r = '1;
    #1;
    exp_q.push_back(0);
    tick();
    #1;
    ch = exp_q.pop_front();
    total++; if (bus_rr.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL ar_busy_pre: got %b want %b", bus_rr.req_busy, ~onehot(ch)); end
    #1;
    rst   = 1'b1;
    req_r = '0;
    #1;
    total++; if (bus_rr.req_busy !== 4'hF) begin bad++; $display("FAIL ar_busy_async: got %b want 1111", bus_rr.req_busy); end
    total++; if (bus_rr.gnt !== 4'h0) begin bad++; $display("FAIL ar_gnt_rst: got %b want 0000", bus_rr.gnt); end
    exp_q.delete();
    tick();
    tick();
    rst   = 1'b0;
    req_r = '1;
    #1;
    total++; if (bus_rr.gnt !== 4'b0001) begin bad++; $display("FAIL ar_gnt_tie: got %b want 0001", bus_rr.gnt); end
    total++; if (bus_rr.req_busy !== 4'hF) begin bad++; $display("FAIL ar_busy_first: got %b want 1111", bus_rr.req_busy); end
    exp_q.push_back(0);
    tick();
    req_r = '0;
    #1;
    ch = exp_q.pop_front();
    total++; if (bus_rr.req_busy !== ~onehot(ch)) begin bad++; $display("FAIL ar_busy_post: got %b want %b", bus_rr.req_busy, ~onehot(ch)); end
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-channel successor to the two-port instruction/data memory arbiter.
- Multiplexes NCH requesters onto the single memory port. Arbitration is fixed-priority or round-robin, selected by parameter.
- Tracks which channel owns the in-flight transaction, so the response and busy are routed only to that channel.
- Sits between the core's fetch/load-store units (plus DMA/debug channels) and the memory controller.

Parameters:
- NCH, 2, number of requester channels (2..8).
- AW, 32, address width.
- DW, 32, data width.
- RR, 1, 1 = round-robin, 0 = fixed priority (channel 0 highest).
- FETCH_CH, 0, channel index whose transactions assert fetch.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_r  in  NCH  per-channel read request.
- req_w  in  NCH  per-channel write request.
- req_sz  in  2*NCH  per-channel size, channel i at [2i+1:2i].
- req_addr  in  AW*NCH  per-channel address, channel i at [AW*i+AW-1:AW*i].
- req_wdata  in  DW*NCH  per-channel write data, same packing.
- req_rdata  out  DW  read data, broadcast to all channels.
- req_busy  out  NCH  per-channel busy.
- gnt  out  NCH  one-hot combinational grant for the current cycle.
- mem_r  out  1  memory read strobe.
- mem_w  out  1  memory write strobe.
- fetch  out  1  high when the granted channel is FETCH_CH.
- mem_sz  out  2  size of the granted request.
- mem_addr  out  AW  address of the granted request.
- mem_wdata  out  DW  write data of the granted request.
- mem_rdata  in  DW  memory read data.
- mem_busy  in  1  memory stall.

Behaviour:
- Request: channel i requests when req_r[i] | req_w[i].
- Grant (combinational):
  - RR=0: lowest-index requesting channel.
  - RR=1: first requesting channel at or after ptr, searching upward with wrap NCH-1 -> 0.
  - No request: gnt=0, mem_r=0, mem_w=0, fetch=0; mem_sz/mem_addr/mem_wdata driven from channel 0 (don't-care).
- Memory-port mux: mem_r, mem_w, mem_sz, mem_addr and mem_wdata come from the granted channel.
- Acceptance: a transaction is accepted on a rising edge where mem_busy=0 and gnt!=0.
  - While mem_busy=1, nothing is accepted, grant may change, and ptr/owner hold.
  - Requesters must hold their request until their req_busy goes low.
- Owner register: owner_vld and owner_id load on every edge with mem_busy=0.
  - owner_vld <= (gnt!=0); owner_id <= index of gnt.
  - Idle cycles clear owner_vld.
- Response and busy:
  - req_busy[i] = !(owner_vld && owner_id==i) || mem_busy.
  - The owning channel sees busy low in the cycle after acceptance, if memory is not stalling.
  - That cycle is single-cycle latency: req_rdata = mem_rdata is valid for reads.
  - All other channels stay busy.
- Pipelining: a new transaction may be accepted in the same cycle the previous owner receives its response. Back-to-back throughput is 1 per cycle.
- Pointer (RR=1): on acceptance of channel g, ptr <= (g==NCH-1) ? 0 : g+1.
  - With RR=0, ptr is unused and held at 0.
  - Fairness: a continuously requesting channel is accepted within NCH accepted transactions.
- Read/write conflict: a channel asserting both req_r and req_w passes both strobes through unchanged. The arbiter does not resolve this.
- Reset (asynchronous, any time including mid-transaction):
  - ptr=0, owner_vld=0, owner_id=0.
  - All req_busy=1.
  - The in-flight response is dropped.
  - mem_r/mem_w follow the combinational grant; requesters must not request during reset.
- First edge after reset release behaves as if idle.
- Widths: ptr and owner_id are $clog2(NCH) bits, minimum 1.

Test Plan:
- Reset with all requests low → req_busy=all 1s, gnt=0, mem_r=0, mem_w=0, fetch=0.
- NCH=4, RR=1, all four request continuously, mem_busy=0 → grants in order 0,1,2,3,0; each owner sees req_busy low exactly one cycle later with req_rdata=mem_rdata.
- RR=0, channels 1 and 3 request → gnt=0010 every cycle; channel 3 stays busy until channel 1 drops its request.
- Channel 2 read at addr 0x100, mem_busy held high 3 cycles → gnt stable, ptr unchanged; req_busy[2] falls one cycle after mem_busy falls; rdata 0xDEADBEEF is delivered to channel 2 only.
- Channel 0 write (wdata 0x12345678, sz 2) back-to-back with channel 1 read → mem_w then mem_r on consecutive cycles; channel 1 busy low on the cycle after its acceptance; fetch=1 only during the channel 0 cycle (FETCH_CH=0).
- Assert rst while owner_vld=1 → req_busy returns to all 1s immediately (asynchronously); after release ptr=0 and channel 0 wins a 4-way tie.
